// File: rtl/smem_arbiter.sv
// rtl/smem_arbiter.sv - round-robin locking arbiter for the single-port RC4 S-array RAM
// Optional burst limit: define SMEM_ARB_MAXBURST_EN to cap accesses per grant at MAX_BURST.
module smem_arbiter #(
    parameter int NUM_REQ   = 3,
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int RD_LAT    = 1,
    parameter int MAX_BURST = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    input  logic [NUM_REQ-1:0]        req_wren,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [DATA_W-1:0]         rdata,
    output logic [NUM_REQ-1:0]        rvalid,
    output logic                      busy,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_data,
    output logic                      mem_wren,
    input  logic [DATA_W-1:0]         mem_q
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {IDLE, OWNED} state_t;

    state_t             state;
    logic [IDX_W-1:0]   owner;
    logic [IDX_W-1:0]   rr;

    logic               owner_req;
    logic               forced;
    logic               access;
    logic               rel;
    logic               take;
    logic [NUM_REQ-1:0] cand;
    logic               win_found;
    logic [IDX_W-1:0]   win_idx;

    logic [RD_LAT-1:0]  tag_v;
    logic [IDX_W-1:0]   tag_idx [RD_LAT];

    if (NUM_REQ < 2 || NUM_REQ > 8 || RD_LAT < 1 || RD_LAT > 4 || MAX_BURST < 1) begin : g_param_check
        $error("smem_arbiter: parameter out of range");
    end

    assign busy      = (state == OWNED);
    assign owner_req = req[owner];
    // The current owner is never a candidate; in IDLE gnt is zero so every requester competes.
    assign cand      = req & ~gnt;

`ifdef SMEM_ARB_MAXBURST_EN
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    logic [CNT_W-1:0] burst_cnt;

    assign forced = busy && (burst_cnt == CNT_W'(MAX_BURST)) && (|cand);

    // Per-grant access counter: cleared on every new grant, saturates at MAX_BURST.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            burst_cnt <= '0;
        end else if (take) begin
            burst_cnt <= '0;
        end else if (access && (burst_cnt != CNT_W'(MAX_BURST))) begin
            burst_cnt <= burst_cnt + 1'b1;
        end
    end
`else
    assign forced = 1'b0;
`endif

    // A forced release is treated like a voluntary one: that cycle performs no access.
    assign access = busy && owner_req && !forced && reset_n;
    assign rel    = busy && (!owner_req || forced);
    assign take   = win_found && (!busy || rel);

    // Round-robin search starting just after rr; rr always equals owner while a grant is held.
    always_comb begin
        int j;
        j         = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            j = int'(rr) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (cand[j]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(j);
            end
        end
    end

    // Grant state machine with registered one-hot grant.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            gnt   <= '0;
            owner <= '0;
            rr    <= IDX_W'(NUM_REQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        gnt   <= NUM_REQ'(1) << win_idx;
                        owner <= win_idx;
                        rr    <= win_idx;
                        state <= OWNED;
                    end
                end
                OWNED: begin
                    if (rel) begin
                        if (win_found) begin
                            gnt   <= NUM_REQ'(1) << win_idx;
                            owner <= win_idx;
                            rr    <= win_idx;
                        end else begin
                            gnt   <= '0;
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    gnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Route the owner's slot to the RAM only during access cycles.
    always_comb begin
        mem_addr = '0;
        mem_data = '0;
        mem_wren = 1'b0;
        if (access) begin
            mem_addr = req_addr[owner*ADDR_W +: ADDR_W];
            mem_data = req_wdata[owner*DATA_W +: DATA_W];
            mem_wren = req_wren[owner];
        end
    end

    // Read-tag pipeline: each read carries its issuer so handovers cannot misroute data.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tag_v <= '0;
            for (int i = 0; i < RD_LAT; i++) tag_idx[i] <= '0;
        end else begin
            tag_v[0]   <= access && !req_wren[owner];
            tag_idx[0] <= owner;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_v[i]   <= tag_v[i-1];
                tag_idx[i] <= tag_idx[i-1];
            end
        end
    end

    // Decode the emerging tag into a one-hot valid pulse.
    always_comb begin
        rvalid = '0;
        if (tag_v[RD_LAT-1] && reset_n) rvalid[tag_idx[RD_LAT-1]] = 1'b1;
    end

    assign rdata = mem_q;

endmodule
